sif_xa_arb_bridge: RTL and testbench

//   Multi-channel SIF bridge. Arbitrates NUM_CH xa-style requestors (write/read strobes,

---
 rtl/sif_xa_arb_bridge.sv | 132 +++++++++++++
 tb/tb_sif_xa_arb_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sif_xa_arb_bridge.sv
// sif_xa_arb_bridge: round-robin arbiter bridging NUM_CH xa requestors onto a
// single wa write port, with a local shadow register file serving reads.
// Optional macro SIF_BRIDGE_ADDR_CHK_EN adds the xa_err port and rejects
// addresses >= DEPTH; without it addresses alias onto the shadow index.
module sif_xa_arb_bridge #(
  parameter int NUM_CH = 2,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    xa_wr_s,
  input  logic [NUM_CH-1:0]    xa_rd_s,
  input  logic [NUM_CH*AW-1:0] xa_addr,
  input  logic [NUM_CH*DW-1:0] xa_data_wr,
  output logic [NUM_CH-1:0]    xa_ready,
  output logic [NUM_CH-1:0]    xa_rd_vld,
  output logic [DW-1:0]        xa_data_rd,
  output logic                 wa_wr_s,
  output logic [AW-1:0]        wa_addr,
  output logic [DW-1:0]        wa_data_wr
`ifdef SIF_BRIDGE_ADDR_CHK_EN
  ,
  output logic [NUM_CH-1:0]    xa_err
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {ARB, ACK} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [DW-1:0]   shadow_q [DEPTH];

  logic [NUM_CH-1:0] req;
  logic            any_req;
  logic            found;
  logic [PW-1:0]   gnt;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_data;
  logic            g_wr;
  logic [IW-1:0]   g_idx;
  logic            g_bad;
  logic            take;

  // Round-robin pick starting at the pointer, plus the granted channel's fields
  always_comb begin
    req     = xa_wr_s | xa_rd_s;
    any_req = |req;
    found   = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NUM_CH]) begin
        found = 1'b1;
        gnt   = PW'((int'(ptr_q) + i) % NUM_CH);
      end
    end
    g_addr = xa_addr[int'(gnt)*AW +: AW];
    g_data = xa_data_wr[int'(gnt)*DW +: DW];
    g_wr   = xa_wr_s[gnt];
    g_idx  = (DEPTH == 1) ? '0 : g_addr[IW-1:0];
`ifdef SIF_BRIDGE_ADDR_CHK_EN
    g_bad  = ({1'b0, g_addr} >= (AW+1)'(DEPTH));
`else
    g_bad  = 1'b0;
`endif
    take   = (state_q == ARB) && any_req;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end

  // Next state: one ACK cycle per grant, no arbitration while in ACK
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (any_req) state_d = ACK;
      ACK:     state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Grant datapath: outputs are registered so they appear in the ACK cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      xa_ready   <= '0;
      xa_rd_vld  <= '0;
      xa_data_rd <= '0;
      wa_wr_s    <= 1'b0;
      wa_addr    <= '0;
      wa_data_wr <= '0;
`ifdef SIF_BRIDGE_ADDR_CHK_EN
      xa_err     <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
    end else begin
      xa_ready  <= '0;
      xa_rd_vld <= '0;
      wa_wr_s   <= 1'b0;
`ifdef SIF_BRIDGE_ADDR_CHK_EN
      xa_err    <= '0;
`endif
      if (take) begin
        xa_ready[gnt] <= 1'b1;
        ptr_q         <= PW'((int'(gnt) + 1) % NUM_CH);
`ifdef SIF_BRIDGE_ADDR_CHK_EN
        xa_err[gnt]   <= g_bad;
`endif
        if (g_wr) begin
          // write wins when both strobes are set; rejected writes touch nothing
          if (!g_bad) begin
            shadow_q[g_idx] <= g_data;
            wa_wr_s         <= 1'b1;
            wa_addr         <= g_addr;
            wa_data_wr      <= g_data;
          end
        end else begin
          xa_rd_vld[gnt] <= 1'b1;
          xa_data_rd     <= g_bad ? '0 : shadow_q[g_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_sif_xa_arb_bridge.sv
// tb_sif_xa_arb_bridge: directed plus randomized checks of the bridge against
// a transaction-level model (shadow array, round-robin pointer).
module tb_sif_xa_arb_bridge;
  localparam int NUM_CH = 2;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH-1:0]    xa_wr_s = '0;
  logic [NUM_CH-1:0]    xa_rd_s = '0;
  logic [NUM_CH*AW-1:0] xa_addr = '0;
  logic [NUM_CH*DW-1:0] xa_data_wr = '0;
  logic [NUM_CH-1:0]    xa_ready, xa_rd_vld;
  logic [DW-1:0]        xa_data_rd;
  logic                 wa_wr_s;
  logic [AW-1:0]        wa_addr;
  logic [DW-1:0]        wa_data_wr;
`ifdef SIF_BRIDGE_ADDR_CHK_EN
  logic [NUM_CH-1:0]    xa_err;
`endif

  always #5 clk = ~clk;

  sif_xa_arb_bridge #(.NUM_CH(NUM_CH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr), .xa_data_wr(xa_data_wr),
    .xa_ready(xa_ready), .xa_rd_vld(xa_rd_vld), .xa_data_rd(xa_data_rd),
    .wa_wr_s(wa_wr_s), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr)
`ifdef SIF_BRIDGE_ADDR_CHK_EN
    , .xa_err(xa_err)
`endif
  );

  int total = 0;
  int bad = 0;
  logic [DW-1:0] mdl [DEPTH];
  int mptr = 0;
  int gnt_log [$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(logic [AW-1:0] a);
`ifdef SIF_BRIDGE_ADDR_CHK_EN
    return a >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_req(int ch, bit wr, bit rd, logic [AW-1:0] a, logic [DW-1:0] d);
    xa_wr_s[ch] = wr;
    xa_rd_s[ch] = rd;
    xa_addr[ch*AW +: AW] = a;
    xa_data_wr[ch*DW +: DW] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mptr = 0;
  endtask

  task automatic chk_outs_zero(string tag);
    chk(tag, {xa_ready, xa_rd_vld, xa_data_rd, wa_wr_s, wa_addr, wa_data_wr}, 64'd0);
`ifdef SIF_BRIDGE_ADDR_CHK_EN
    chk({tag, "_err"}, xa_err, 0);
`endif
  endtask

  // Wait for the next accept, check it against the model, optionally drop the strobe
  task automatic wait_ack(bit drop);
    int exp_ch = -1;
    bit got = 1'b0;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit b;
    int idx;
    for (int i = 0; i < NUM_CH; i++)
      if (exp_ch < 0 && (xa_wr_s[(mptr+i)%NUM_CH] | xa_rd_s[(mptr+i)%NUM_CH]))
        exp_ch = (mptr + i) % NUM_CH;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (xa_ready != '0) got = 1'b1;
      else chk("idle_pulse", {xa_rd_vld, wa_wr_s}, 0);
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    chk("ready", xa_ready, 64'd1 << exp_ch);
    gnt_log.push_back(exp_ch);
    a = xa_addr[exp_ch*AW +: AW];
    d = xa_data_wr[exp_ch*DW +: DW];
    b = addr_bad(a);
    idx = int'(a) % DEPTH;
    if (xa_wr_s[exp_ch]) begin
      chk("wr_strobe", wa_wr_s, !b);
      chk("wr_no_rdvld", xa_rd_vld, 0);
      if (!b) begin
        chk("wa_addr", wa_addr, a);
        chk("wa_data", wa_data_wr, d);
        mdl[idx] = d;
      end
    end else begin
      chk("rd_vld", xa_rd_vld, 64'd1 << exp_ch);
      chk("rd_data", xa_data_rd, b ? '0 : mdl[idx]);
      chk("rd_no_wr", wa_wr_s, 0);
    end
`ifdef SIF_BRIDGE_ADDR_CHK_EN
    chk("err", xa_err, b ? (64'd1 << exp_ch) : 64'd0);
`endif
    mptr = (exp_ch + 1) % NUM_CH;
    if (drop) set_req(exp_ch, 1'b0, 1'b0, a, d);
  endtask

  initial begin
    bit got;
    model_reset();

    // 1: reset for 3 cycles, outputs clear, read of addr 5 returns 0
    repeat (3) @(negedge clk);
    chk_outs_zero("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs_zero("rst_release");
    set_req(0, 0, 1, 16'd5, 16'h0);
    wait_ack(1);

    // 2: write then read back the same address
    set_req(0, 1, 0, 16'd3, 16'hA5A5);
    wait_ack(1);
    set_req(0, 0, 1, 16'd3, 16'h0);
    wait_ack(1);
    chk("rd_back", xa_data_rd, 16'hA5A5);

    // 3: both channels held for 4 grants must alternate
    gnt_log.delete();
    set_req(0, 0, 1, 16'd3, 16'h0);
    set_req(1, 1, 0, 16'd9, 16'h0F0F);
    repeat (4) wait_ack(0);
    set_req(0, 0, 0, 16'd0, 16'h0);
    set_req(1, 0, 0, 16'd0, 16'h0);
    chk("rr_count", gnt_log.size(), 4);
    for (int i = 1; i < gnt_log.size(); i++) chk("rr_alt", gnt_log[i] != gnt_log[i-1], 1);

    // 4: wr and rd together are a write
    repeat (2) @(negedge clk);
    set_req(1, 1, 1, 16'd7, 16'h1234);
    wait_ack(1);

    // 5: reset during the ACK of a write, then read that address
    set_req(0, 1, 0, 16'd2, 16'hBEEF);
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (xa_ready != '0) got = 1'b1;
    end
    chk("rst_ack_seen", got, 1);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("rst_mid_ack");
    set_req(0, 0, 0, 16'd0, 16'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 0, 1, 16'd2, 16'h0);
    wait_ack(1);
    chk("rst_cleared_shadow", xa_data_rd, 0);

    // 6: address just past DEPTH: error with the check, aliasing without it
    set_req(0, 1, 0, 16'h0010, 16'h5A5A);
    wait_ack(1);
    set_req(0, 0, 1, 16'h0000, 16'h0);
    wait_ack(1);
`ifndef SIF_BRIDGE_ADDR_CHK_EN
    chk("alias_rd", xa_data_rd, 16'h5A5A);
`endif

    // randomized traffic with requests left pending across grants
    for (int t = 0; t < 80; t++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (!(xa_wr_s[c] | xa_rd_s[c]) && ($urandom_range(0, 1) == 1))
          set_req(c, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, DEPTH + 3)), DW'($urandom));
      if ((xa_wr_s | xa_rd_s) == '0)
        set_req(0, 0, 1, AW'($urandom_range(0, DEPTH - 1)), 16'h0);
      wait_ack(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule
